// File: rtl/lbc_req_sched_pkg.sv
// Shared encodings for the local bus request scheduler: FSM states,
// command-select bit positions and the pending-request bundle.
package lbc_req_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } st_e;

    localparam int NSEL   = 4;
    localparam int SEL_EJ = 0;
    localparam int SEL_I  = 1;
    localparam int SEL_DR = 2;
    localparam int SEL_DW = 3;

    typedef struct packed {
        logic e;
        logic d;
        logic i;
    } pend_t;

endpackage

// File: rtl/lbc_wcnt.sv
// Write-buffer occupancy tracker: counter, one-hot load decode, valid mask
// and full/empty flags.
module lbc_wcnt #(
    parameter int NWRITES = 4
) (
    input  logic               SYSCLK,
    input  logic               RESET_D1_R,
    input  logic               dwreq,
    input  logic               shift,
    output logic [NWRITES-1:0] load,
    output logic [NWRITES-1:0] vmask,
    output logic               full,
    output logic               empty
);
    localparam int CW = $clog2(NWRITES + 1);

    logic [CW-1:0] wcnt;
    logic [CW-1:0] idx;
    logic          shift_e;
    logic          accept;

    assign full    = (wcnt == CW'(NWRITES));
    assign empty   = (wcnt == '0);
    assign shift_e = shift & ~empty;
    // A store into a full buffer is only legal when the head pops the same cycle.
    assign accept  = dwreq & (~full | shift_e);
    assign idx     = wcnt - CW'(shift_e);

    for (genvar i = 0; i < NWRITES; i++) begin : g_ent
        assign load[i]  = accept & (idx == CW'(i));
        assign vmask[i] = (CW'(i) < wcnt);
    end

    always_ff @(posedge SYSCLK or posedge RESET_D1_R) begin
        if (RESET_D1_R)
            wcnt <= '0;
        else if (accept & ~shift_e)
            wcnt <= wcnt + CW'(1);
        else if (~accept & shift_e)
            wcnt <= wcnt - CW'(1);
    end

endmodule

// File: rtl/lbc_req_sched.sv
// Local bus request scheduler: captures I/D/store/EJTAG requests and
// sequences them onto the single bus command slot.
module lbc_req_sched
    import lbc_req_sched_pkg::*;
#(
    parameter int NWRITES = 4
) (
    input  logic               SYSCLK,
    input  logic               RESET_D1_R,
    input  logic               CBUS_IREQ,
    input  logic               CBUS_DREQ,
    input  logic               CBUS_DWREQ,
    input  logic               EJ_DMAREQ,
    input  logic [NWRITES-1:0] LD_FCTLHIT,
    input  logic               LL_CACK,
    input  logic               LL_CDONE,
    output logic [NSEL-1:0]    LC_CQSEL,
    output logic               LC_CILOAD,
    output logic               LC_CDRLOAD,
    output logic [NWRITES-1:0] LC_FCTLLOAD,
    output logic               LC_FCTLDOSHIFT,
    output logic               LC_DVALID_R,
    output logic               LC_EJDONE,
    output logic               LC_WFULL,
    output logic               LC_IPEND,
    output logic               LC_DPEND
);
    st_e                st;
    pend_t              pend;
    pend_t              owner;
    logic [NSEL-1:0]    pick;
    logic [NWRITES-1:0] vmask;
    logic               hit;
    logic               wempty;
    logic               shift;

    assign LC_CILOAD      = CBUS_IREQ & ~pend.i & ~RESET_D1_R;
    assign LC_CDRLOAD     = CBUS_DREQ & ~pend.d & ~RESET_D1_R;
    assign shift          = (st == ST_ISSUE) & LL_CACK & LC_CQSEL[SEL_DW];
    assign LC_FCTLDOSHIFT = shift;
    assign hit            = |(LD_FCTLHIT & vmask);
    assign LC_DVALID_R    = pend.d;
    assign LC_IPEND       = pend.i;
    assign LC_DPEND       = pend.d;

    lbc_wcnt #(.NWRITES(NWRITES)) u_wcnt (
        .SYSCLK     (SYSCLK),
        .RESET_D1_R (RESET_D1_R),
        .dwreq      (CBUS_DWREQ & ~RESET_D1_R),
        .shift      (shift),
        .load       (LC_FCTLLOAD),
        .vmask      (vmask),
        .full       (LC_WFULL),
        .empty      (wempty)
    );

    // A pending read that hits a buffered store flushes the buffer first (RAW).
    always_comb begin
        pick = '0;
        if (pend.e)             pick[SEL_EJ] = 1'b1;
        else if (pend.d && hit) pick[SEL_DW] = 1'b1;
        else if (pend.d)        pick[SEL_DR] = 1'b1;
        else if (pend.i)        pick[SEL_I]  = 1'b1;
        else if (!wempty)       pick[SEL_DW] = 1'b1;
    end

    always_ff @(posedge SYSCLK or posedge RESET_D1_R) begin
        if (RESET_D1_R) begin
            st        <= ST_IDLE;
            pend      <= '0;
            owner     <= '0;
            LC_CQSEL  <= '0;
            LC_EJDONE <= 1'b0;
        end else begin
            LC_EJDONE <= 1'b0;
            if (LC_CILOAD)  pend.i <= 1'b1;
            if (LC_CDRLOAD) pend.d <= 1'b1;
            if (EJ_DMAREQ)  pend.e <= 1'b1;
            case (st)
                ST_IDLE: begin
                    if (|pick) begin
                        LC_CQSEL <= pick;
                        owner    <= '{e: pick[SEL_EJ], d: pick[SEL_DR], i: pick[SEL_I]};
                        st       <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (LL_CACK) begin
                        LC_CQSEL <= '0;
                        st       <= LC_CQSEL[SEL_DW] ? ST_IDLE : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (LL_CDONE) begin
                        st <= ST_IDLE;
                        if (owner.e) begin
                            pend.e    <= 1'b0;
                            LC_EJDONE <= 1'b1;
                        end
                        if (owner.d) pend.d <= 1'b0;
                        if (owner.i) pend.i <= 1'b0;
                    end
                end
                default: st <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/lbc_req_sched.md
# lbc_req_sched

Request scheduler and sequencer for the local bus controller datapath. It captures instruction-miss, data-read-miss, store and EJTAG DMA requests and arbitrates them onto the single outgoing bus command slot. It also drives the one-hot command-queue select, the load/shift controls of the write buffer, and read-after-write flushing from the write-buffer hit vector. It sits between the CPU/EJTAG request side and the `lbc_data` datapath in the SYSCLK domain.

## Interface
- `NWRITES`, default 4, write-buffer depth in entries (2..8).
- `SYSCLK`  in  1  system clock; all state on rising edge.
- `RESET_D1_R`  in  1  reset, asynchronous, active-high.
- `CBUS_IREQ`  in  1  instruction-miss request pulse.
- `CBUS_DREQ`  in  1  data-read-miss request pulse.
- `CBUS_DWREQ`  in  1  store request pulse; data accompanies on CBUS.
- `EJ_DMAREQ`  in  1  EJTAG DMA request pulse.
- `LD_FCTLHIT`  in  NWRITES  per-entry write-buffer address/uncached hit against the latched read address.
- `LL_CACK`  in  1  bus side accepted the presented command (1-cycle pulse).
- `LL_CDONE`  in  1  bus side completed the outstanding read (1-cycle pulse).
- `LC_CQSEL`  out  4  one-hot command select: [0] EJ, [1] I, [2] DR, [3] DW; 0 when idle.
- `LC_CILOAD`  out  1  capture instruction address.
- `LC_CDRLOAD`  out  1  capture data-read address.
- `LC_FCTLLOAD`  out  NWRITES  one-hot write-buffer entry load.
- `LC_FCTLDOSHIFT`  out  1  pop write-buffer head.
- `LC_DVALID_R`  out  1  data-read request pending.
- `LC_EJDONE`  out  1  EJTAG DMA complete, 1-cycle pulse.
- `LC_WFULL`  out  1  write buffer full; CPU must stall stores.
- `LC_IPEND`, `LC_DPEND`  out  1 each  I/D request outstanding.

## Operation
- Reset values: every output 0, FSM IDLE, `wcnt`=0, pending flags `ipend`/`dpend`/`epend` 0. A reset asserted mid-transaction abandons it with no done pulse.
- Request capture:
  - `CBUS_IREQ` with `ipend`=0: `LC_CILOAD` is pulsed combinationally in the same cycle and `ipend` is set.
  - `CBUS_DREQ` with `dpend`=0: `LC_CDRLOAD` is pulsed combinationally in the same cycle and `dpend` is set.
  - `EJ_DMAREQ` sets `epend`.
  - Any request arriving while its own flag is set is ignored.
- Store capture: `CBUS_DWREQ` loads the entry at index `wcnt - shift`, where `shift` is `LC_FCTLDOSHIFT` in the same cycle. Then `wcnt` += 1 - shift.
  - `CBUS_DWREQ` while `LC_WFULL` and no shift is a protocol error; it is dropped with no counter change.
  - `LC_WFULL` = (`wcnt` == NWRITES).
- `hit` = |(`LD_FCTLHIT` & valid mask), where the valid mask has bits [wcnt-1:0] set.
- FSM states:
  - IDLE: select, in priority order: `epend` → EJ; `dpend` & `hit` → DW (RAW flush); `dpend` & ~`hit` → DR; `ipend` → I; `wcnt`≠0 → DW. Register the selection into `LC_CQSEL` and go to ISSUE. Nothing eligible: stay.
  - ISSUE: `LC_CQSEL` held. On `LL_CACK`:
    - DW: pulse `LC_FCTLDOSHIFT`, return to IDLE (posted write).
    - EJ/I/DR: go to WAIT.
  - WAIT: `LC_CQSEL` = 0. On `LL_CDONE`, clear the owner's pending flag and return to IDLE. An EJ owner also pulses `LC_EJDONE`.
- `LC_DVALID_R` = `dpend`; `LC_IPEND` = `ipend`; `LC_DPEND` = `dpend`.
- `LL_CACK` outside ISSUE and `LL_CDONE` outside WAIT are ignored.

## Timing
- Request at cycle t: pending flag visible at t+1. IDLE evaluates at t+1 (`hit` valid then, since the read address was latched at t). `LC_CQSEL` asserts at t+2 at the earliest.
- Command latency is 2 cycles minimum; reads occupy the slot until `LL_CDONE`.
- A `CBUS_DWREQ` and a shift in the same cycle leave `wcnt` unchanged; the load index is `wcnt`-1.
- `wcnt` saturates in 0..NWRITES and never wraps.

## Structure
- Shared package: FSM state encoding (IDLE/ISSUE/WAIT), CQSEL bit-index constants (EJ=0, I=1, DR=2, DW=3).
- Sub-module `lbc_wcnt`: occupancy counter, one-hot load decoder, valid mask and full flag.

## Test plan
- `CBUS_DREQ` at t, empty buffer → `LC_CDRLOAD`=1 at t, `LC_CQSEL`=4'b0100 at t+2. `LL_CACK` then `LL_CDONE` → `LC_DPEND`=0.
- Three stores, then `CBUS_DREQ` with `LD_FCTLHIT`=4'b0100 → three DW commands with three `LC_FCTLDOSHIFT` pulses precede `LC_CQSEL`=4'b0100.
- `EJ_DMAREQ`, `CBUS_IREQ` and `CBUS_DREQ` in the same cycle → EJ issued first, then DR, then I. `LC_EJDONE` pulses once.
- Four stores with no bus acks → `LC_WFULL`=1, `LC_FCTLLOAD` sequence 0001, 0010, 0100, 1000. A store coinciding with a shift loads 1000 and `wcnt` stays 4.
- `RESET_D1_R` asserted in WAIT → all outputs 0 immediately. After release, IDLE with no `LC_EJDONE`.
